// File: rtl/sm3_pad_stream_if.sv
// rtl/sm3_pad_stream_if.sv - message-in / padded-beat-out bus for the SM3 padder
interface sm3_pad_stream_if #(
  parameter int INPT_DW = 64
) ();
  localparam int BYTE_N = INPT_DW / 8;

  logic [INPT_DW-1:0] msg_d_i;
  logic [BYTE_N-1:0]  msg_byte_en_i;
  logic               msg_vld_i;
  logic               msg_lst_i;
  logic               msg_rdy_o;
  logic [INPT_DW-1:0] pad_d_o;
  logic               pad_vld_o;
  logic               pad_rdy_i;
  logic               pad_blk_lst_o;
  logic               pad_msg_lst_o;
  logic               pad_err_o;

  modport master (
    output msg_d_i, msg_byte_en_i, msg_vld_i, msg_lst_i, pad_rdy_i,
    input  msg_rdy_o, pad_d_o, pad_vld_o, pad_blk_lst_o, pad_msg_lst_o, pad_err_o
  );

  modport slave (
    input  msg_d_i, msg_byte_en_i, msg_vld_i, msg_lst_i, pad_rdy_i,
    output msg_rdy_o, pad_d_o, pad_vld_o, pad_blk_lst_o, pad_msg_lst_o, pad_err_o
  );
endinterface

// File: rtl/sm3_pad_stream.sv
// rtl/sm3_pad_stream.sv - byte-exact SM3 message padder with output back-pressure
module sm3_pad_stream #(
  parameter int INPT_DW = 64,
  parameter int LEN_W   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  sm3_pad_stream_if.slave bus
);
  localparam int BYTE_N   = INPT_DW / 8;
  localparam int BEAT_BLK = 512 / INPT_DW;
  localparam int IDX_W    = $clog2(BEAT_BLK);
  localparam int CNT_W    = LEN_W - 3;
  localparam int K_W      = $clog2(BYTE_N + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEAT_BLK - 1);
  // First beat carrying the length: 32-bit needs two beats, wider widths need one
  localparam logic [IDX_W-1:0] LEN_IDX  = (INPT_DW == 32) ? IDX_W'(BEAT_BLK - 2) : LAST_IDX;

  typedef enum logic [2:0] {S_IDLE, S_PASS, S_MARK, S_FILL, S_LEN} state_t;

  state_t             r_state, w_state_n, w_after_mark;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n, w_cnt_acc;
  logic [IDX_W-1:0]   r_idx, w_idx_n, w_idx_inc;
  logic [INPT_DW-1:0] r_pad_d, w_pad_d_n, w_marked;
  logic               r_pad_vld, r_blk_lst, r_msg_lst, r_err;
  logic               w_adv, w_rdy, w_accept, w_emit, w_done, w_err_n, w_fold_ok;
  logic [K_W-1:0]     w_k;
  logic [BYTE_N-1:0]  w_exp_en;
  logic               w_illegal;
  logic [LEN_W-1:0]   w_len_cur, w_len_acc;
  logic [63:0]        w_len64_cur, w_len64_acc;

  assign w_adv     = ~r_pad_vld | bus.pad_rdy_i;
  assign w_rdy     = rst_n & w_adv & ((r_state == S_IDLE) | (r_state == S_PASS));
  assign w_accept  = w_rdy & bus.msg_vld_i;
  assign w_idx_inc = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);

  always_comb begin
    w_k = '0;
    for (int b = 0; b < BYTE_N; b++) begin
      w_k = w_k + K_W'(bus.msg_byte_en_i[b]);
    end
  end

  assign w_exp_en  = ~({BYTE_N{1'b1}} >> w_k);
  assign w_illegal = (bus.msg_byte_en_i != w_exp_en) |
                     (~bus.msg_lst_i & (w_k != K_W'(BYTE_N)));

  // Last partial beat: keep the k valid bytes, put the marker at byte k, zero the rest
  always_comb begin
    w_marked = '0;
    for (int b = 0; b < BYTE_N; b++) begin
      if (b < int'(w_k)) begin
        w_marked[INPT_DW-1-8*b -: 8] = bus.msg_d_i[INPT_DW-1-8*b -: 8];
      end else if (b == int'(w_k)) begin
        w_marked[INPT_DW-1-8*b -: 8] = 8'h80;
      end
    end
  end

  assign w_cnt_acc   = r_cnt + CNT_W'(w_k);
  assign w_len_cur   = {r_cnt, 3'b000};
  assign w_len_acc   = {w_cnt_acc, 3'b000};
  assign w_len64_cur = 64'(w_len_cur);
  assign w_len64_acc = 64'(w_len_acc);

  // A 128-bit marker beat in the last slot of a block can also carry the length
  assign w_fold_ok    = (INPT_DW == 128) && (r_idx == LAST_IDX);
  assign w_after_mark = (w_idx_inc == LEN_IDX) ? S_LEN : S_FILL;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_emit    = 1'b0;
    w_done    = 1'b0;
    w_err_n   = 1'b0;
    w_pad_d_n = '0;
    case (r_state)
      S_IDLE, S_PASS: begin
        if (w_accept) begin
          w_emit    = 1'b1;
          w_cnt_n   = w_cnt_acc;
          w_err_n   = w_illegal;
          w_state_n = S_PASS;
          w_pad_d_n = bus.msg_d_i;
          if (bus.msg_lst_i) begin
            if (w_k == K_W'(BYTE_N)) begin
              w_state_n = S_MARK;
            end else if (w_fold_ok && (int'(w_k) <= BYTE_N - 9)) begin
              w_pad_d_n = w_marked | INPT_DW'(w_len64_acc);
              w_done    = 1'b1;
            end else begin
              w_pad_d_n = w_marked;
              w_state_n = w_after_mark;
            end
          end
        end
      end
      S_MARK: begin
        if (w_adv) begin
          w_emit = 1'b1;
          if (w_fold_ok) begin
            w_pad_d_n = {8'h80, {(INPT_DW-8){1'b0}}} | INPT_DW'(w_len64_cur);
            w_done    = 1'b1;
          end else begin
            w_pad_d_n = {8'h80, {(INPT_DW-8){1'b0}}};
            w_state_n = w_after_mark;
          end
        end
      end
      S_FILL: begin
        if (w_adv) begin
          w_emit    = 1'b1;
          w_state_n = w_after_mark;
        end
      end
      S_LEN: begin
        if (w_adv) begin
          w_emit = 1'b1;
          if ((INPT_DW == 32) && (r_idx != LAST_IDX)) begin
            w_pad_d_n = INPT_DW'(w_len64_cur[63:32]);
          end else begin
            w_pad_d_n = INPT_DW'(w_len64_cur);
            w_done    = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_emit) begin
      w_idx_n = w_idx_inc;
    end
    if (w_done) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
      w_idx_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pad_d   <= '0;
      r_pad_vld <= 1'b0;
      r_blk_lst <= 1'b0;
      r_msg_lst <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_n;
      r_idx <= w_idx_n;
      r_err <= w_err_n;
      if (w_adv) begin
        r_pad_vld <= w_emit;
        r_pad_d   <= w_pad_d_n;
        r_blk_lst <= w_emit & (r_idx == LAST_IDX);
        r_msg_lst <= w_done;
      end
    end
  end

  assign bus.msg_rdy_o     = w_rdy;
  assign bus.pad_d_o       = r_pad_d;
  assign bus.pad_vld_o     = r_pad_vld;
  assign bus.pad_blk_lst_o = r_blk_lst;
  assign bus.pad_msg_lst_o = r_msg_lst;
  assign bus.pad_err_o     = r_err;
endmodule

// File: tb/tb_sm3_pad_stream.sv
// tb/tb_sm3_pad_stream.sv - randomized and directed bench for sm3_pad_stream
module tb_sm3_pad_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm3_pad_stream_if #(.INPT_DW(32))  b32 ();
  sm3_pad_stream_if #(.INPT_DW(64))  b64 ();
  sm3_pad_stream_if #(.INPT_DW(128)) b128 ();

  sm3_pad_stream #(.INPT_DW(32),  .LEN_W(64)) u32  (.clk(clk), .rst_n(rst_n), .bus(b32));
  sm3_pad_stream #(.INPT_DW(64),  .LEN_W(64)) u64  (.clk(clk), .rst_n(rst_n), .bus(b64));
  sm3_pad_stream #(.INPT_DW(128), .LEN_W(64)) u128 (.clk(clk), .rst_n(rst_n), .bus(b128));

  int           sel_bw = 8;
  logic [127:0] d = '0;
  logic [15:0]  en = '0;
  logic         vld = 1'b0, lst = 1'b0, rdy = 1'b1;

  assign b32.msg_d_i        = d[31:0];
  assign b32.msg_byte_en_i  = en[3:0];
  assign b32.msg_vld_i      = vld && (sel_bw == 4);
  assign b32.msg_lst_i      = lst;
  assign b32.pad_rdy_i      = rdy;
  assign b64.msg_d_i        = d[63:0];
  assign b64.msg_byte_en_i  = en[7:0];
  assign b64.msg_vld_i      = vld && (sel_bw == 8);
  assign b64.msg_lst_i      = lst;
  assign b64.pad_rdy_i      = rdy;
  assign b128.msg_d_i       = d;
  assign b128.msg_byte_en_i = en;
  assign b128.msg_vld_i     = vld && (sel_bw == 16);
  assign b128.msg_lst_i     = lst;
  assign b128.pad_rdy_i     = rdy;

  logic [127:0] o_d;
  logic         o_vld, o_blk, o_msg, o_err, o_mrdy;
  always_comb begin
    o_d = 128'(b64.pad_d_o); o_vld = b64.pad_vld_o; o_blk = b64.pad_blk_lst_o;
    o_msg = b64.pad_msg_lst_o; o_err = b64.pad_err_o; o_mrdy = b64.msg_rdy_o;
    if (sel_bw == 4) begin
      o_d = 128'(b32.pad_d_o); o_vld = b32.pad_vld_o; o_blk = b32.pad_blk_lst_o;
      o_msg = b32.pad_msg_lst_o; o_err = b32.pad_err_o; o_mrdy = b32.msg_rdy_o;
    end else if (sel_bw == 16) begin
      o_d = b128.pad_d_o; o_vld = b128.pad_vld_o; o_blk = b128.pad_blk_lst_o;
      o_msg = b128.pad_msg_lst_o; o_err = b128.pad_err_o; o_mrdy = b128.msg_rdy_o;
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  int err_cnt = 0;
  int err_run = 0;
  logic o_err_q = 1'b0;
  logic [7:0]   msg_q[$];
  logic [127:0] exp_d[$];
  bit           exp_blk[$];
  bit           exp_msg[$];

  always @(negedge clk) begin
    if (o_err) err_cnt++;
    if (o_err && o_err_q) err_run++;
    o_err_q = o_err;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden padding: bytes, 0x80, zeros up to 56 mod 64, then 64-bit big-endian bit length
  task automatic build_exp(input int bw, input logic [63:0] bits);
    logic [7:0] p[$];
    int nb, bpb;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb  = p.size() / bw;
    bpb = 64 / bw;
    exp_d.delete(); exp_blk.delete(); exp_msg.delete();
    for (int j = 0; j < nb; j++) begin
      logic [127:0] v = '0;
      for (int b = 0; b < bw; b++) v[(bw-1-b)*8 +: 8] = p[j*bw + b];
      exp_d.push_back(v);
      exp_blk.push_back((j % bpb) == bpb - 1);
      exp_msg.push_back(j == nb - 1);
    end
  endtask

  task automatic gen_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive(input int bw, input int gaps, input int err_beat);
    int len, nb, t;
    len = msg_q.size();
    nb  = (len == 0) ? 1 : (len + bw - 1) / bw;
    for (int j = 0; j < nb; j++) begin
      if (gaps != 0 && $urandom_range(0, 3) == 0) begin
        vld = 1'b0;
        @(posedge clk); #1;
      end
      d = '0; en = '0;
      for (int b = 0; b < bw; b++) begin
        if (j*bw + b < len) begin
          d[(bw-1-b)*8 +: 8] = msg_q[j*bw + b];
          en[bw-1-b] = 1'b1;
        end
      end
      if (j == err_beat) begin
        for (int b = bw/2; b < bw; b++) en[bw-1-b] = 1'b0;
      end
      lst = (j == nb - 1);
      vld = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!o_mrdy && t < 1000);
      if (t >= 1000) chk("drv_timeout", 128'(o_mrdy), 128'(1));
      @(posedge clk); #1;
    end
    vld = 1'b0; lst = 1'b0; en = '0;
  endtask

  task automatic monitor(input int stall, input int rnd);
    int i = 0, cyc = 0;
    bit stalled = 0;
    while (i < exp_d.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (o_vld && rdy) begin
        chk("beat_data", o_d, exp_d[i]);
        chk("blk_lst", 128'(o_blk), 128'(exp_blk[i]));
        chk("msg_lst", 128'(o_msg), 128'(exp_msg[i]));
        i++;
      end
      @(posedge clk); #1;
      if (stall != 0 && i == 3 && !stalled) begin
        stalled = 1;
        rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_data", o_d, exp_d[i]);
          chk("stall_vld", 128'(o_vld), 128'(1));
          chk("stall_msg_rdy", 128'(o_mrdy), 128'(0));
          @(posedge clk); #1;
        end
        rdy = 1'b1;
      end else begin
        rdy = (rnd != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    chk("beat_count", 128'(i), 128'(exp_d.size()));
    rdy = 1'b1;
  endtask

  task automatic run_msg(input int bw, input int stall, input int rnd, input int err_beat,
                         input logic [63:0] bits);
    sel_bw = bw;
    build_exp(bw, bits);
    rdy = 1'b1;
    #1;
    fork
      drive(bw, (stall != 0) ? 0 : rnd, err_beat);
      monitor(stall, rnd);
    join
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "global timeout");
  end

  initial begin
    int len, bw;
    #1;
    chk("rst_vld", 128'(o_vld), 128'(0));
    chk("rst_data", o_d, 128'(0));
    chk("rst_blk", 128'(o_blk), 128'(0));
    chk("rst_msg", 128'(o_msg), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_msg_rdy", 128'(o_mrdy), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(4, 0, 0, -1, 64'd24);
    gen_msg(55);
    run_msg(8, 0, 0, -1, 64'd440);
    gen_msg(56);
    run_msg(8, 0, 0, -1, 64'd448);
    msg_q.delete();
    run_msg(16, 0, 0, -1, 64'd0);
    gen_msg(55);
    run_msg(16, 0, 0, -1, 64'd440);
    gen_msg(48);
    run_msg(16, 0, 0, -1, 64'd384);
    gen_msg(60);
    run_msg(4, 0, 0, -1, 64'd480);

    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 2))
        0: bw = 4;
        1: bw = 8;
        default: bw = 16;
      endcase
      len = $urandom_range(0, 130);
      gen_msg(len);
      run_msg(bw, 0, 1, -1, 64'(len * 8));
    end

    gen_msg(40);
    run_msg(8, 1, 0, -1, 64'd320);

    sel_bw = 4;
    msg_q = '{8'h61, 8'h62, 8'h63};
    drive(4, 0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_vld", 128'(o_vld), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("fill_rst_vld", 128'(o_vld), 128'(0));
    chk("fill_rst_data", o_d, 128'(0));
    chk("fill_rst_blk", 128'(o_blk), 128'(0));
    chk("fill_rst_msg", 128'(o_msg), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_msg(4, 0, 0, -1, 64'd24);

    gen_msg(24);
    err_cnt = 0;
    err_run = 0;
    run_msg(8, 0, 0, 1, 64'd160);
    chk("err_pulses", 128'(err_cnt), 128'(1));
    chk("err_width", 128'(err_run), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
